vpu_alu_si_div: RTL and testbench

Iterative signed-integer divider for the VPU ALU. It is the inverse operation of the signed multiply lane.
- Accepts a dividend/divisor pair from the SRC_PORT path under VPU_CONTROLLER enable.
- Runs a radix-2 restoring divide over OPERAND_WIDTH cycles.
- Returns a truncated (round-toward-zero) quotient and remainder to VPU_DST_PORT with a one-cycle valid pulse.

---
 rtl/vpu_alu_si_div_pkg.sv | 23 ++
 rtl/vpu_alu_si_div_step.sv | 29 ++
 rtl/vpu_alu_si_div.sv | 154 +++++++++++++++
 tb/tb_vpu_alu_si_div.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vpu_alu_si_div_pkg.sv
// Shared types and constants for the VPU signed-integer divide lane.
// Pure definitions: no logic, no latency, no flow control.
package vpu_alu_si_div_pkg;

    localparam int OPERAND_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [OPERAND_WIDTH-1:0] SI_MIN     = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
    localparam logic [OPERAND_WIDTH-1:0] SI_NEG_ONE = {OPERAND_WIDTH{1'b1}};

    // Result sign fix-up applied after the unsigned magnitude divide.
    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
    } div_sign_t;

endpackage

// File: rtl/vpu_alu_si_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor.
// Latency: combinational. Backpressure: none, purely a function of its inputs.
module vpu_alu_si_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W:0]   divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] quo_out
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] diff;

    assign rem_sh = {rem_in, quo_in[W-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // A borrow out of the top bit means the trial subtract failed: restore.
    always_comb begin
        rem_out = diff[W:0];
        quo_out = {quo_in[W-2:0], 1'b1};
        if (diff[W+1]) begin
            rem_out = rem_sh[W:0];
            quo_out = {quo_in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/vpu_alu_si_div.sv
// Iterative signed divider, truncating quotient, remainder follows dividend; VPU_SI_DIV_EARLY_OUT_EN enables |op_0|<|op_1| bypass.
// Latency: OPERAND_WIDTH+2 cycles accept-to-valid; divide-by-zero, MIN/-1 (and early-out) answer in 1.
// Backpressure: none queued; en is ignored while busy_o is high, valid_o is a single-cycle pulse.
module vpu_alu_si_div #(
    parameter int OPERAND_WIDTH = vpu_alu_si_div_pkg::OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [OPERAND_WIDTH-1:0] op_0,
    input  logic [OPERAND_WIDTH-1:0] op_1,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic [OPERAND_WIDTH-1:0] result_o,
    output logic [OPERAND_WIDTH-1:0] rem_o,
    output logic                     div_by_zero_o
);

    import vpu_alu_si_div_pkg::*;

    localparam int W     = OPERAND_WIDTH;
    localparam int CNT_W = $clog2(OPERAND_WIDTH) + 1;

    localparam logic [W-1:0] MIN_V     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] NEG_ONE_V = {W{1'b1}};

    div_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W:0]       rem_q, rem_nxt;
    logic [W-1:0]     quo_q, quo_nxt;
    logic [W:0]       dvsr_q, dvsr_nxt;
    div_sign_t        sign_q, sign_nxt;

    logic [W-1:0]     result_nxt, rem_o_nxt;
    logic             dbz_nxt;

    logic [W:0]       abs_0, abs_1;
    logic [W:0]       step_rem;
    logic [W-1:0]     step_quo;
    logic             early_out;

    // One extra magnitude bit so that |MIN| is representable.
    assign abs_0 = op_0[W-1] ? -{op_0[W-1], op_0} : {op_0[W-1], op_0};
    assign abs_1 = op_1[W-1] ? -{op_1[W-1], op_1} : {op_1[W-1], op_1};

`ifdef VPU_SI_DIV_EARLY_OUT_EN
    assign early_out = (abs_0 < abs_1);
`else
    assign early_out = 1'b0;
`endif

    vpu_alu_si_div_step #(
        .W(W)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem_q;
        quo_nxt    = quo_q;
        dvsr_nxt   = dvsr_q;
        sign_nxt   = sign_q;
        result_nxt = result_o;
        rem_o_nxt  = rem_o;
        dbz_nxt    = div_by_zero_o;

        case (state)
            IDLE: begin
                if (en) begin
                    sign_nxt.neg_quo = op_0[W-1] ^ op_1[W-1];
                    sign_nxt.neg_rem = op_0[W-1];
                    dvsr_nxt         = abs_1;
                    rem_nxt          = '0;
                    quo_nxt          = W'(abs_0);
                    cnt_nxt          = CNT_W'(W);
                    if (op_1 == '0) begin
                        state_nxt  = DONE;
                        result_nxt = NEG_ONE_V;
                        rem_o_nxt  = op_0;
                        dbz_nxt    = 1'b1;
                    end else if (op_0 == MIN_V && op_1 == NEG_ONE_V) begin
                        state_nxt  = DONE;
                        result_nxt = MIN_V;
                        rem_o_nxt  = '0;
                        dbz_nxt    = 1'b0;
                    end else if (early_out) begin
                        state_nxt  = DONE;
                        result_nxt = '0;
                        rem_o_nxt  = op_0;
                        dbz_nxt    = 1'b0;
                    end else begin
                        state_nxt  = CALC;
                    end
                end
            end
            CALC: begin
                rem_nxt = step_rem;
                quo_nxt = step_quo;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                result_nxt = sign_q.neg_quo ? -quo_q : quo_q;
                rem_o_nxt  = W'(sign_q.neg_rem ? -rem_q : rem_q);
                dbz_nxt    = 1'b0;
                state_nxt  = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            sign_q        <= '0;
            busy_o        <= 1'b0;
            valid_o       <= 1'b0;
            result_o      <= '0;
            rem_o         <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rem_q         <= rem_nxt;
            quo_q         <= quo_nxt;
            dvsr_q        <= dvsr_nxt;
            sign_q        <= sign_nxt;
            busy_o        <= (state_nxt != IDLE);
            valid_o       <= (state_nxt == DONE);
            result_o      <= result_nxt;
            rem_o         <= rem_o_nxt;
            div_by_zero_o <= dbz_nxt;
        end
    end

endmodule

// File: tb/tb_vpu_alu_si_div.sv
// Directed bench for vpu_alu_si_div: vector table plus back-to-back and mid-op reset sequences.
module tb_vpu_alu_si_div;

    localparam int W = 32;
`ifdef VPU_SI_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 34;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] op_0, op_1;
    logic         busy_o, valid_o, div_by_zero_o;
    logic [W-1:0] result_o, rem_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vpu_alu_si_div dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .op_0          (op_0),
        .op_1          (op_1),
        .busy_o        (busy_o),
        .valid_o       (valid_o),
        .result_o      (result_o),
        .rem_o         (rem_o),
        .div_by_zero_o (div_by_zero_o)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   W'(busy_o),        '0);
        check({tag, "_valid"},  W'(valid_o),       '0);
        check({tag, "_result"}, result_o,          '0);
        check({tag, "_rem"},    rem_o,             '0);
        check({tag, "_dbz"},    W'(div_by_zero_o), '0);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int k;
        @(negedge clk);
        op_0 = v.a;
        op_1 = v.b;
        en   = 1'b1;
        @(negedge clk);
        en   = 1'b0;
        op_0 = $urandom;
        op_1 = $urandom;
        k = 1;
        while (k <= 60 && !valid_o) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, W'(k), W'(v.lat));
        check({name, "_result"},  result_o, v.q);
        check({name, "_rem"},     rem_o, v.r);
        check({name, "_dbz"},     W'(div_by_zero_o), W'(v.dbz));
        check({name, "_busy_at_valid"}, W'(busy_o), W'(1));
        @(negedge clk);
        check({name, "_valid_pulse"}, W'(valid_o), '0);
    endtask

    initial begin
        int  k;
        bit  busy_drop;
        bit  spurious;

        vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{-32'd100,     32'd7,          -32'd14,        -32'd2,         1'b0, 34};
        vecs[2]  = '{32'd100,      -32'd7,         -32'd14,        32'd2,          1'b0, 34};
        vecs[3]  = '{-32'd100,     -32'd7,         32'd14,         -32'd2,         1'b0, 34};
        vecs[4]  = '{32'd5,        32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
        vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          1'b0, 1};
        vecs[6]  = '{32'd3,        32'd8,          32'd0,          32'd3,          1'b0, EO_LAT};
        vecs[7]  = '{32'h8000_0000, 32'd1,         32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 32'd1,          32'd0,          1'b0, 34};
        vecs[9]  = '{32'd7,        32'h8000_0000,  32'd0,          32'd7,          1'b0, EO_LAT};
        vecs[10] = '{-32'd7,       32'd0,          32'hFFFF_FFFF,  -32'd7,         1'b1, 1};
        vecs[11] = '{32'h7FFF_FFFF, 32'd2,         32'h3FFF_FFFF,  32'd1,          1'b0, 34};
        vecs[12] = '{-32'd1,       32'd2,          32'd0,          -32'd1,         1'b0, EO_LAT};

        rst_n = 1'b0;
        en    = 1'b0;
        op_0  = '0;
        op_1  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // en held high across two operations: the second waits for the first valid_o.
        @(negedge clk);
        op_0 = 32'd10;
        op_1 = 32'd3;
        en   = 1'b1;
        @(negedge clk);
        op_0 = 32'd9;
        busy_drop = 1'b0;
        k = 1;
        while (k <= 60 && !valid_o) begin
            if (!busy_o) busy_drop = 1'b1;
            @(negedge clk);
            k++;
        end
        check("b2b_first_latency", W'(k), W'(34));
        check("b2b_first_result",  result_o, 32'd3);
        check("b2b_first_rem",     rem_o, 32'd1);
        @(negedge clk);
        check("b2b_gap_busy", W'(busy_o), '0);
        k = 1;
        while (k <= 80 && !valid_o) begin
            @(negedge clk);
            k++;
            if (!valid_o && !busy_o) busy_drop = 1'b1;
        end
        en = 1'b0;
        check("b2b_second_latency", W'(k), W'(35));
        check("b2b_second_result",  result_o, 32'd3);
        check("b2b_second_rem",     rem_o, 32'd0);
        check("b2b_busy_never_dropped", W'(busy_drop), '0);

        // Reset in the middle of a divide aborts it without a valid pulse.
        @(negedge clk);
        @(negedge clk);
        op_0 = 32'd20;
        op_1 = 32'd4;
        en   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("midop_reset");
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) spurious = 1'b1;
        end
        check("midop_no_valid", W'(spurious), '0);
        run_op("after_reset", '{32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 34});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
